// File: rtl/ace_mem_arbiter.sv
// ace_mem_arbiter
//   Shares one synchronous single-port RAM between the Z80 (ace core) and the
//   data_io ROM/file downloader. Download bytes pass through a one-entry holding
//   register and throttle data_io through ioctl_wait. CPU accesses are stalled
//   through cpu_wait. rom_ready releases the CPU once an image is present.
//   A pending download byte always wins over a pending CPU access, but an access
//   that has started is never pre-empted.
//
// Optional feature:
//   ACE_MEMARB_CHECKSUM_EN - adds output dl_csum[7:0]. It holds the XOR of every
//   byte written to RAM by the downloader and clears when a new download starts.

module ace_mem_arbiter #(
   parameter int                ADDR_W    = 16,
   parameter int                MEM_LAT   = 2,
   parameter logic [7:0]        DL_INDEX  = 8'd0,
   parameter logic [ADDR_W-1:0] DL_BASE   = '0,
   parameter bit                PRELOADED = 1'b0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_cpu,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   output logic [7:0]        cpu_dout,
   output logic              cpu_wait,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   input  logic [7:0]        mem_dout,
   output logic              rom_ready,
   output logic              dl_overrun
`ifdef ACE_MEMARB_CHECKSUM_EN
   ,
   output logic [7:0]        dl_csum
`endif
);

   // CRD counts MEM_LAT cycles; the counter only needs to reach MEM_LAT-1.
   localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DL,
      ST_CRD,
      ST_CWR
   } state_t;

   state_t state;
   state_t state_nx;

   logic [LAT_W-1:0]  lat_cnt;
   logic              lat_done;

   logic              hold_valid;
   logic [ADDR_W-1:0] hold_addr;
   logic [7:0]        hold_data;

   logic              cpu_pend;
   logic              cpu_ack;
   logic              wrote_any;

   logic              dl_in_range;
   logic              dl_accept;
   logic [ADDR_W-1:0] dl_target;
   logic              cpu_req;
   logic              cpu_new;
   logic              cpu_want;
   logic              access_done;

   // Download byte qualification: right file, active download, address inside the RAM.
   assign dl_in_range = ((ioctl_addr >> ADDR_W) == 25'd0);
   assign dl_accept   = ioctl_wr & ioctl_download & (ioctl_index == DL_INDEX) & dl_in_range;
   assign dl_target   = DL_BASE + ADDR_W'(ioctl_addr);

   // CPU handshake: a request is taken once, on a clock-enable cycle, and then
   // remembered in cpu_pend until the access completes.
   assign cpu_req     = cpu_rd | cpu_wr;
   assign cpu_new     = ce_cpu & cpu_req & ~cpu_ack & ~cpu_pend;
   assign cpu_want    = cpu_pend | cpu_new;
   assign cpu_wait    = cpu_req & ~cpu_ack;

   assign lat_done    = (lat_cnt == LAT_LAST);
   assign access_done = ((state == ST_CRD) && lat_done) || (state == ST_CWR);

   // data_io is held off for as long as a byte sits in the holding register.
   assign ioctl_wait  = hold_valid;

   // State register.
   always_ff @(posedge clk_sys) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block ordering.
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state selection and RAM port drive.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nx = state;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
      mem_we   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hold_valid || dl_accept) begin
               state_nx = ST_DL;
            end else if (cpu_want) begin
               state_nx = cpu_wr ? ST_CWR : ST_CRD;
            end
         end
         ST_DL: begin
            mem_addr = hold_addr;
            mem_din  = hold_data;
            mem_we   = ~reset;
            state_nx = ST_IDLE;
         end
         ST_CRD: begin
            if (lat_done) begin
               state_nx = ST_IDLE;
            end
         end
         ST_CWR: begin
            mem_we   = ~reset;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Read latency counter: runs only while in CRD, restarts for every access.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         lat_cnt <= '0;
      end else if ((state == ST_CRD) && !lat_done) begin
         lat_cnt <= lat_cnt + 1'b1;
      end else begin
         lat_cnt <= '0;
      end
   end

   // Holding register control: filled by an accepted byte, emptied by the DL write.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hold_valid <= 1'b0;
         dl_overrun <= 1'b0;
      end else begin
         if (state == ST_DL) begin
            hold_valid <= 1'b0;
         end
         if (dl_accept) begin
            if (hold_valid) begin
               dl_overrun <= 1'b1;
            end else begin
               hold_valid <= 1'b1;
            end
         end
      end
   end

   // Holding register payload, loaded alongside hold_valid.
   always_ff @(posedge clk_sys) begin
      // NOTE: payload registers are not reset; hold_valid alone says whether
      // they mean anything, so resetting them would only add reset fan-out.
      if (dl_accept && !hold_valid) begin
         hold_addr <= dl_target;
         hold_data <= ioctl_dout;
      end
   end

   // CPU side: pending flag, acknowledge and read data capture.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_pend <= 1'b0;
         cpu_ack  <= 1'b0;
         cpu_dout <= 8'h00;
      end else begin
         if (cpu_new) begin
            cpu_pend <= 1'b1;
         end
         if (access_done) begin
            cpu_pend <= 1'b0;
            cpu_ack  <= 1'b1;
         end else if (!cpu_req) begin
            cpu_ack  <= 1'b0;
         end
         if ((state == ST_CRD) && lat_done) begin
            cpu_dout <= mem_dout;
         end
      end
   end

   // rom_ready: sticky once a download has landed in RAM and data_io is idle.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wrote_any <= 1'b0;
         rom_ready <= PRELOADED;
      end else begin
         if (state == ST_DL) begin
            wrote_any <= 1'b1;
         end
         if (!ioctl_download && wrote_any && !hold_valid) begin
            rom_ready <= 1'b1;
         end
      end
   end

`ifdef ACE_MEMARB_CHECKSUM_EN
   logic dl_prev;

   // Running XOR of downloaded bytes; a new download (rising ioctl_download) restarts it.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_prev <= 1'b0;
         dl_csum <= 8'h00;
      end else begin
         dl_prev <= ioctl_download;
         if (ioctl_download && !dl_prev) begin
            dl_csum <= 8'h00;
         end else if (state == ST_DL) begin
            dl_csum <= dl_csum ^ hold_data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ace_mem_arbiter.sv
// tb_ace_mem_arbiter
//   Self-checking bench for ace_mem_arbiter. The RAM is modelled here with a
//   MEM_LAT-stage read pipeline. Directed sequences cover reset, a full download,
//   download filtering (vector table), arbitration, overrun and reset mid-access.
//   A randomized phase runs CPU traffic against a concurrent paced download and
//   compares against a plain memory reference model.

module tb_ace_mem_arbiter;

   localparam int ADDR_W  = 16;
   localparam int MEM_LAT = 2;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              ce_cpu;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_din;
   logic              cpu_rd;
   logic              cpu_wr;
   logic [7:0]        cpu_dout;
   logic              cpu_wait;
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_we;
   logic [7:0]        mem_dout;
   logic              rom_ready;
   logic              dl_overrun;
`ifdef ACE_MEMARB_CHECKSUM_EN
   logic [7:0]        dl_csum;
`endif

   always #5 clk_sys = ~clk_sys;

   ace_mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .MEM_LAT   (MEM_LAT),
      .DL_INDEX  (8'd0),
      .DL_BASE   (16'h0000),
      .PRELOADED (1'b0)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ce_cpu         (ce_cpu),
      .cpu_addr       (cpu_addr),
      .cpu_din        (cpu_din),
      .cpu_rd         (cpu_rd),
      .cpu_wr         (cpu_wr),
      .cpu_dout       (cpu_dout),
      .cpu_wait       (cpu_wait),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_we         (mem_we),
      .mem_dout       (mem_dout),
      .rom_ready      (rom_ready),
      .dl_overrun     (dl_overrun)
`ifdef ACE_MEMARB_CHECKSUM_EN
      ,
      .dl_csum        (dl_csum)
`endif
   );

   // RAM model: synchronous write, MEM_LAT-cycle read pipeline, write counter.
   logic [7:0]  ram [0:65535];
   logic [7:0]  rd_p1;
   logic [7:0]  rd_p2;
   int unsigned we_count = 0;

   always @(posedge clk_sys) begin
      rd_p1 <= ram[mem_addr];
      rd_p2 <= rd_p1;
      if (mem_we) begin
         ram[mem_addr] <= mem_din;
         we_count      <= we_count + 1;
      end
   end
   assign mem_dout = rd_p2;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // One-cycle download strobe; returns in the cycle after the strobe.
   task automatic dl_pulse(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      ioctl_wr    = 1'b1;
      step();
      ioctl_wr    = 1'b0;
   endtask

   // data_io pacing: wait (bounded) for ioctl_wait to drop, then move to the next cycle.
   task automatic dl_drain(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk_sys);
         if (!ioctl_wait) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
   endtask

   // Full CPU access from request to release. lat is the cycle (request cycle = 0)
   // in which cpu_wait is first seen low, or -1 if the bound expired.
   task automatic cpu_access(input bit wr, input logic [15:0] addr, input logic [7:0] din,
                             output logic [7:0] dout, output int lat);
      cpu_addr = addr;
      cpu_din  = din;
      cpu_rd   = ~wr;
      cpu_wr   = wr;
      ce_cpu   = 1'b1;
      lat      = -1;
      dout     = 8'h00;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk_sys);
         if (!cpu_wait) begin
            lat  = n;
            dout = cpu_dout;
            break;
         end
         step();
         ce_cpu = 1'b0;
      end
      step();
      ce_cpu = 1'b0;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      step();
   endtask

   typedef struct {
      logic        dl;
      logic [7:0]  idx;
      logic [24:0] addr;
      logic [7:0]  data;
      logic        exp_acc;
   } dl_vec_t;

   dl_vec_t vec [7];

   // Reference model for the randomized phase.
   logic [7:0] ref_mem [int];
   logic [7:0] dl_exp  [200];

   int unsigned we0;
   int          lat;
   logic [7:0]  got;
   bit          ok;
   int          errs;
   int          rnd_lat_errs;
   int          rnd_to;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Download filter vectors: {download, index, addr, data, expect accepted}.
      vec[0] = '{1'b1, 8'd1,   25'h0003000, 8'hA1, 1'b0};
      vec[1] = '{1'b1, 8'd0,   25'h0010000, 8'hA2, 1'b0};
      vec[2] = '{1'b0, 8'd0,   25'h0003001, 8'hA3, 1'b0};
      vec[3] = '{1'b1, 8'd0,   25'h0003002, 8'hA4, 1'b1};
      vec[4] = '{1'b1, 8'd0,   25'h000FFFF, 8'hA5, 1'b1};
      vec[5] = '{1'b1, 8'd0,   25'h1FF0000, 8'hA6, 1'b0};
      vec[6] = '{1'b1, 8'hFF,  25'h0003003, 8'hA7, 1'b0};

      reset          = 1'b1;
      ce_cpu         = 1'b0;
      cpu_addr       = '0;
      cpu_din        = 8'h00;
      cpu_rd         = 1'b0;
      cpu_wr         = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'h00;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = 8'h00;

      // Reset values.
      step();
      step();
      @(negedge clk_sys);
      check("rst_cpu_wait",   cpu_wait,   1'b0);
      check("rst_ioctl_wait", ioctl_wait, 1'b0);
      check("rst_mem_we",     mem_we,     1'b0);
      check("rst_rom_ready",  rom_ready,  1'b0);
      check("rst_dl_overrun", dl_overrun, 1'b0);
      check("rst_cpu_dout",   cpu_dout,   8'h00);
`ifdef ACE_MEMARB_CHECKSUM_EN
      check("rst_dl_csum",    dl_csum,    8'h00);
`endif
      step();
      reset = 1'b0;

      // T1: full paced download of 0x0000..0x1FFF, RAM[a] = a[7:0].
      ioctl_download = 1'b1;
      step();
      errs = 0;
      for (int a = 0; a < 'h2000; a++) begin
         dl_pulse(8'd0, 25'(a), 8'(a));
         @(negedge clk_sys);
         if (!ioctl_wait) errs++;
         dl_drain(ok);
         if (!ok) errs++;
      end
      check("t1_pacing_errors", errs, 0);
      errs = 0;
      for (int a = 0; a < 'h2000; a++) begin
         if (ram[a] !== 8'(a)) errs++;
      end
      check("t1_ram_mismatches", errs, 0);
      @(negedge clk_sys);
      check("t1_rom_ready_during_dl", rom_ready, 1'b0);
      step();
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      check("t1_rom_ready_fall_cycle", rom_ready, 1'b0);
      step();
      @(negedge clk_sys);
      check("t1_rom_ready_after_fall", rom_ready, 1'b1);
      check("t1_dl_overrun", dl_overrun, 1'b0);
      step();

      // T2 and download filtering, table driven.
      for (int i = 0; i < 7; i++) begin
         ioctl_download = vec[i].dl;
         step();
         we0 = we_count;
         dl_pulse(vec[i].idx, vec[i].addr, vec[i].data);
         @(negedge clk_sys);
         check($sformatf("vec%0d_ioctl_wait", i), ioctl_wait, vec[i].exp_acc);
         step();
         @(negedge clk_sys);
         check($sformatf("vec%0d_wait_released", i), ioctl_wait, 1'b0);
         step();
         step();
         check($sformatf("vec%0d_ram_writes", i), we_count - we0, 32'(vec[i].exp_acc));
         if (vec[i].exp_acc) begin
            check($sformatf("vec%0d_ram_data", i), ram[vec[i].addr[15:0]], vec[i].data);
         end
      end
      ioctl_download = 1'b0;
      step();
      step();
      check("t2_rom_ready_sticky", rom_ready, 1'b1);

      // T3: CPU read and accepted download byte in the same cycle; DL goes first.
      ioctl_download = 1'b1;
      step();
      ioctl_index = 8'd0;
      ioctl_addr  = 25'h0002000;
      ioctl_dout  = 8'h5A;
      ioctl_wr    = 1'b1;
      cpu_addr    = 16'h1234;
      cpu_rd      = 1'b1;
      ce_cpu      = 1'b1;
      step();
      ioctl_wr = 1'b0;
      ce_cpu   = 1'b0;
      @(negedge clk_sys);
      check("t3_dl_first_we",   mem_we,   1'b1);
      check("t3_dl_first_addr", mem_addr, 16'h2000);
      lat = -1;
      for (int n = 1; n < 64; n++) begin
         if (!cpu_wait) begin
            lat = n;
            break;
         end
         step();
         @(negedge clk_sys);
      end
      check("t3_read_latency", lat, 2 + 1 + MEM_LAT);
      check("t3_cpu_dout", cpu_dout, 8'h34);
      step();
      cpu_rd = 1'b0;
      step();
      check("t3_dl_ram", ram[16'h2000], 8'h5A);

      // T4: back-to-back strobes; the second byte is dropped.
      we0 = we_count;
      dl_pulse(8'd0, 25'h0002100, 8'h11);
      dl_pulse(8'd0, 25'h0002101, 8'h22);
      step();
      step();
      step();
      check("t4_ram_writes", we_count - we0, 32'd1);
      check("t4_first_byte", ram[16'h2100], 8'h11);
      check("t4_dl_overrun", dl_overrun, 1'b1);

      // Best-case CPU latencies with the bus idle.
      cpu_access(1'b1, 16'h9000, 8'hC3, got, lat);
      check("cpu_write_latency", lat, 2);
      cpu_access(1'b0, 16'h9000, 8'h00, got, lat);
      check("cpu_read_latency", lat, 1 + MEM_LAT);
      check("cpu_read_back", got, 8'hC3);

      // Randomized CPU traffic against a concurrent paced download.
      rnd_lat_errs = 0;
      rnd_to       = 0;
      fork
         begin : dl_proc
            int guard;
            logic [7:0] d;
            for (int k = 0; k < 200; k++) begin
               repeat ($urandom_range(0, 3)) step();
               guard = 0;
               while (ioctl_wait && guard < 64) begin
                  step();
                  guard++;
               end
               if (guard >= 64) rnd_to++;
               d = 8'($urandom);
               dl_exp[k] = d;
               dl_pulse(8'd0, 25'h0004000 + 25'(k), d);
            end
         end
         begin : cpu_proc
            logic [15:0] a;
            logic [7:0]  d;
            logic [7:0]  r;
            bit          w;
            int          l;
            for (int k = 0; k < 300; k++) begin
               repeat ($urandom_range(0, 2)) step();
               a = 16'h8000 + 16'($urandom_range(0, 31));
               w = !ref_mem.exists(32'(a)) || ($urandom_range(0, 1) == 1);
               d = 8'($urandom);
               cpu_access(w, a, d, r, l);
               if (l < 0) rnd_to++;
               if (w) begin
                  if (l < 2) rnd_lat_errs++;
                  ref_mem[32'(a)] = d;
               end else begin
                  if (l < 1 + MEM_LAT) rnd_lat_errs++;
                  check($sformatf("rnd_read_%0h", a), r, ref_mem[32'(a)]);
               end
            end
         end
      join
      step();
      step();
      check("rnd_timeouts", rnd_to, 0);
      check("rnd_latency_errors", rnd_lat_errs, 0);
      errs = 0;
      foreach (ref_mem[a]) begin
         if (ram[a] !== ref_mem[a]) errs++;
      end
      check("rnd_cpu_ram_mismatches", errs, 0);
      errs = 0;
      for (int k = 0; k < 200; k++) begin
         if (ram[16'h4000 + k] !== dl_exp[k]) errs++;
      end
      check("rnd_dl_ram_mismatches", errs, 0);
      check("rnd_dl_overrun_sticky", dl_overrun, 1'b1);

      // T5: reset while in CRD with a byte waiting in the holding register.
      ioctl_download = 1'b1;
      step();
      cpu_addr = 16'h1234;
      cpu_rd   = 1'b1;
      ce_cpu   = 1'b1;
      step();
      ce_cpu      = 1'b0;
      ioctl_index = 8'd0;
      ioctl_addr  = 25'h0002200;
      ioctl_dout  = 8'h77;
      ioctl_wr    = 1'b1;
      step();
      ioctl_wr = 1'b0;
      we0      = we_count;
      reset    = 1'b1;
      @(negedge clk_sys);
      check("t5_pre_cpu_wait",   cpu_wait,   1'b1);
      check("t5_pre_ioctl_wait", ioctl_wait, 1'b1);
      step();
      reset          = 1'b0;
      cpu_rd         = 1'b0;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      check("t5_cpu_wait",   cpu_wait,   1'b0);
      check("t5_ioctl_wait", ioctl_wait, 1'b0);
      check("t5_rom_ready",  rom_ready,  1'b0);
      check("t5_dl_overrun", dl_overrun, 1'b0);
      check("t5_cpu_dout",   cpu_dout,   8'h00);
      step();
      step();
      step();
      step();
      check("t5_no_ram_write",     we_count - we0, 32'd0);
      check("t5_rom_ready_stays0", rom_ready, 1'b0);

`ifdef ACE_MEMARB_CHECKSUM_EN
      // T6: checksum of a fresh download.
      ioctl_download = 1'b1;
      step();
      dl_pulse(8'd0, 25'h0000100, 8'h0F);
      dl_drain(ok);
      dl_pulse(8'd0, 25'h0000101, 8'hF0);
      dl_drain(ok);
      dl_pulse(8'd0, 25'h0000102, 8'h55);
      dl_drain(ok);
      ioctl_download = 1'b0;
      step();
      check("t6_dl_csum", dl_csum, 8'hAA);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
